// File: rtl/k12a_mem_arbiter_pkg.sv
// Shared k12a types: CPU sequencer states and memory arbiter states.
// Also holds the latched debug transaction bundle.
package k12a_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB
   } state_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SETUP,
      ARB_STROBE,
      ARB_HOLD
   } arb_state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } dbg_xact_t;

endpackage

// File: rtl/k12a_mem_arbiter_if.sv
// Debug/loader port: level request held until a one-cycle ack.
// Also carries the read data and the sticky ROM-write error flag.
interface k12a_mem_arbiter_if;

   logic        dbg_req;
   logic        dbg_we;
   logic [15:0] dbg_addr;
   logic [7:0]  dbg_wdata;
   logic        dbg_ack;
   logic [7:0]  dbg_rdata;
   logic        dbg_rom_wr_err;

   modport master (
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata, dbg_rom_wr_err
   );

   modport slave (
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata, dbg_rom_wr_err
   );

endinterface

// File: rtl/k12a_mem_decode.sv
// Region select and active-low strobe decode for one bus master.
// Region select: addr[15]=0 is ROM, addr[15]=1 is RAM.
module k12a_mem_decode (
   input  logic ram_sel,
   input  logic we,
   input  logic en,
   input  logic wr_en,
   output logic rom_ce_n,
   output logic ram_ce_n,
   output logic oe_n,
   output logic we_n
);

   assign rom_ce_n = !(en && !ram_sel);
   assign ram_ce_n = !(en && ram_sel);
   assign oe_n     = !(en && !we);
   assign we_n     = !(en && we && wr_en);

endmodule

// File: rtl/k12a_mem_arbiter.sv
// Shares the memory bus between the CPU and the debug/loader port.
// A debug transaction runs SETUP/STROBE/HOLD and is never aborted by the CPU.
module k12a_mem_arbiter
   import k12a_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic          cpu_clock,
   input  logic          reset_n,
   input  logic          cpu_mem_req,
   input  logic [15:0]   cpu_addr,
   input  logic          cpu_we,
   output logic          cpu_stall,
   k12a_mem_arbiter_if.slave dbg,
   output logic [15:0]   mem_addr,
   output logic          mem_rom_ce_n,
   output logic          mem_ram_ce_n,
   output logic          mem_oe_n,
   output logic          mem_we_n,
   output logic [7:0]    mem_wdata,
   output logic          mem_wdata_oe,
   input  logic [7:0]    mem_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_t    state, state_nx;
   dbg_xact_t     lat;
   logic [CW-1:0] starve_cnt;
   logic [7:0]    rdata_q;
   logic          err_q;
   logic          dbg_win, dbg_en, dbg_wr_en;
   logic          busy, rom_wr;

   logic c_rom, c_ram, c_oe, c_we;
   logic d_rom, d_ram, d_oe, d_we;

   // A ROM write is carried through the FSM but never strobes the bus.
   assign rom_wr = lat.we && !lat.addr[15];
   assign busy   = (state != ARB_IDLE);

   always_comb begin
      state_nx  = state;
      dbg_win   = 1'b0;
      dbg_en    = 1'b0;
      dbg_wr_en = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            dbg_win = dbg.dbg_req &&
                      (!cpu_mem_req || starve_cnt == LIMIT);
            if (dbg_win) state_nx = ARB_SETUP;
         end
         ARB_SETUP: begin
            dbg_en   = !rom_wr;
            state_nx = ARB_STROBE;
         end
         ARB_STROBE: begin
            dbg_en    = !rom_wr;
            dbg_wr_en = 1'b1;
            state_nx  = ARB_HOLD;
         end
         ARB_HOLD: state_nx = ARB_IDLE;
         default:  state_nx = ARB_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ARB_IDLE;
         lat        <= '0;
         starve_cnt <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nx;
         if (dbg_win) begin
            lat.addr   <= dbg.dbg_addr;
            lat.we     <= dbg.dbg_we;
            lat.wdata  <= dbg.dbg_wdata;
            starve_cnt <= '0;
            if (dbg.dbg_we && !dbg.dbg_addr[15]) err_q <= 1'b1;
         end else if (state == ARB_IDLE && dbg.dbg_req &&
                      cpu_mem_req && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
         if (state == ARB_STROBE && !lat.we) rdata_q <= mem_rdata;
      end
   end

   k12a_mem_decode u_cpu_dec (
      .ram_sel  (cpu_addr[15]),
      .we       (cpu_we),
      .en       (cpu_mem_req),
      .wr_en    (1'b1),
      .rom_ce_n (c_rom),
      .ram_ce_n (c_ram),
      .oe_n     (c_oe),
      .we_n     (c_we)
   );

   k12a_mem_decode u_dbg_dec (
      .ram_sel  (lat.addr[15]),
      .we       (lat.we),
      .en       (dbg_en),
      .wr_en    (dbg_wr_en),
      .rom_ce_n (d_rom),
      .ram_ce_n (d_ram),
      .oe_n     (d_oe),
      .we_n     (d_we)
   );

   assign mem_addr     = busy ? lat.addr : cpu_addr;
   assign mem_rom_ce_n = !reset_n || (busy ? d_rom : c_rom);
   assign mem_ram_ce_n = !reset_n || (busy ? d_ram : c_ram);
   assign mem_oe_n     = !reset_n || (busy ? d_oe  : c_oe);
   assign mem_we_n     = !reset_n || (busy ? d_we  : c_we);
   assign mem_wdata    = lat.wdata;
   assign mem_wdata_oe = reset_n && busy && lat.we;

   assign cpu_stall = reset_n && cpu_mem_req && (busy || dbg_win);

   assign dbg.dbg_ack        = (state == ARB_HOLD);
   assign dbg.dbg_rdata      = rdata_q;
   assign dbg.dbg_rom_wr_err = err_q;

endmodule
